fetch_pf: RTL and testbench

FETCH_PF -- requirements
Module: fetch_pf

---
 rtl/fetch_pkg.sv | 6 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_pf.sv | 125 ++++++++++++
 tb/tb_fetch_pf.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;
  localparam int PC_STEP   = 2;
  localparam int NOP_INSTR = 0;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: power-of-two ring buffer with flush and occupancy count.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Push into a full queue is only legal alongside a pop; the head is read before the edge.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= din;
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_q];
endmodule

// File: rtl/fetch_pf.sv
// Instruction prefetch: single-outstanding memory fetch into a small queue, with redirect and sticky error.
module fetch_pf
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter int          INSTR_W  = 16,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  input  logic               en,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               mem_done,
  input  logic               mem_stall,
  input  logic               mem_err,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_inc,
  output logic               instr_valid,
  output logic               nop,
  output logic               err
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e                      state_q, state_d;
  logic [ADDR_W-1:0]           fpc_q, fpc_d, req_addr_q, req_addr_d, fpc_next;
  logic                        err_q, err_d;
  logic [CW-1:0]               count;
  logic [INSTR_W+ADDR_W-1:0]   head;
  logic                        push, pop, can_issue;
  logic                        stall_unused;

  // The request is held until mem_done regardless of stall, so stall carries no extra information.
  assign stall_unused = mem_stall;

  assign fpc_next    = fpc_q + ADDR_W'(PC_STEP);
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & en & ~redirect;
  assign instr       = instr_valid ? head[INSTR_W+ADDR_W-1:ADDR_W] : INSTR_W'(NOP_INSTR);
  assign pc_inc      = instr_valid ? head[ADDR_W-1:0] : '0;
  assign nop         = redirect | ~instr_valid;
  assign err         = err_q;

  fetch_fifo #(.W(INSTR_W + ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({mem_data, fpc_next}),
    .count (count),
    .head  (head)
  );

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    req_addr_d = req_addr_q;
    err_d      = err_q | mem_err;
    push       = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = req_addr_q;
    can_issue  = (state_q == IDLE) & ~halt & ~redirect & ~err_q &
                 ((count - CW'(pop)) < CW'(DEPTH));
    case (state_q)
      IDLE: begin
        mem_addr = fpc_q;
        if (redirect) begin
          fpc_d = redirect_pc;
        end else if (can_issue) begin
          if (fpc_q[0]) begin
            err_d = 1'b1;
          end else begin
            mem_rd     = 1'b1;
            req_addr_d = fpc_q;
            if (mem_done) begin
              push  = 1'b1;
              fpc_d = fpc_next;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        mem_rd = 1'b1;
        if (redirect) begin
          fpc_d   = redirect_pc;
          state_d = mem_done ? IDLE : DRAIN;
        end else if (mem_done) begin
          push    = 1'b1;
          fpc_d   = fpc_next;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        // Stale request stays on the bus at its original address until it completes.
        mem_rd = 1'b1;
        if (redirect) fpc_d = redirect_pc;
        if (mem_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) mem_rd = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fpc_q      <= ADDR_W'(RESET_PC);
      req_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      req_addr_q <= req_addr_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_fetch_pf.sv
// Randomized bench for fetch_pf against a queue-based reference model, plus directed scenarios.
module tb_fetch_pf;
  localparam int AW = 16, IW = 16, DEPTH = 4;

  logic          clk = 0, rst = 0, redirect = 0, halt = 0, en = 0;
  logic          mem_done = 0, mem_stall = 0, mem_err = 0;
  logic [AW-1:0] redirect_pc = '0;
  logic [IW-1:0] mem_data = '0;
  logic          mem_rd, instr_valid, nop, err;
  logic [AW-1:0] mem_addr, pc_inc;
  logic [IW-1:0] instr;

  always #5 clk = ~clk;

  fetch_pf #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .en(en), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_done(mem_done), .mem_stall(mem_stall),
    .mem_err(mem_err), .instr(instr), .pc_inc(pc_inc),
    .instr_valid(instr_valid), .nop(nop), .err(err)
  );

  int tests = 0, fails = 0;

  // Reference model: fetch PC, a queue of fetched words, and whether a request
  // is in flight and whether its answer is still wanted.
  logic [AW-1:0] m_fpc, m_req;
  logic          m_out, m_drain, m_err;
  int            m_wait, lat;
  logic [IW-1:0] q_i[$];
  logic [AW-1:0] q_p[$];

  logic          s_rd, s_vld, s_nop, s_err;
  logic [AW-1:0] s_addr, s_pcinc;
  logic [IW-1:0] s_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fpc = '0; m_req = '0; m_out = 0; m_drain = 0; m_err = 0; m_wait = 0;
    q_i.delete(); q_p.delete();
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic do_reset();
    rst = 1; redirect = 0; halt = 0; en = 0; mem_done = 0; mem_err = 0; mem_stall = 0;
    #1;
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_pc_inc", 32'(pc_inc), 0);
    chk("rst_nop", 32'(nop), 1);
    chk("rst_err", 32'(err), 0);
    @(posedge clk); @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic step(input logic r, input logic [AW-1:0] rpc, input logic h,
                      input logic e, input logic merr);
    logic e_pop, e_would, e_rd, e_done;
    logic [AW-1:0] e_addr;
    logic [IW-1:0] d;
    redirect = r; redirect_pc = rpc; halt = h; en = e; mem_err = merr;
    d = IW'($urandom); mem_data = d;
    e_pop = (q_i.size() > 0) && e && !r;
    if (m_out) begin
      e_would = 0; e_rd = 1; e_addr = m_req;
    end else begin
      e_would = !h && !r && !m_err && ((int'(q_i.size()) - int'(e_pop)) < DEPTH);
      e_rd = e_would && !m_fpc[0];
      e_addr = m_fpc;
    end
    e_done = e_rd && (m_wait >= lat);
    mem_done = e_done;
    mem_stall = e_rd && !e_done;
    #1;
    s_rd = mem_rd; s_addr = mem_addr; s_vld = instr_valid; s_instr = instr;
    s_pcinc = pc_inc; s_nop = nop; s_err = err;
    chk("mem_rd", 32'(s_rd), 32'(e_rd));
    if (e_rd) chk("mem_addr", 32'(s_addr), 32'(e_addr));
    chk("instr_valid", 32'(s_vld), 32'(q_i.size() > 0));
    chk("instr", 32'(s_instr), (q_i.size() > 0) ? 32'(q_i[0]) : 0);
    chk("pc_inc", 32'(s_pcinc), (q_i.size() > 0) ? 32'(q_p[0]) : 0);
    chk("nop", 32'(s_nop), 32'(r || q_i.size() == 0));
    chk("err", 32'(s_err), 32'(m_err));
    @(posedge clk);
    if (merr || (e_would && m_fpc[0])) m_err = 1;
    if (e_rd && !e_done) m_wait++; else m_wait = 0;
    if (r) begin
      q_i.delete(); q_p.delete();
      m_out = m_out && !e_done;
      m_drain = m_out;
      m_fpc = rpc;
    end else begin
      if (e_pop) begin void'(q_i.pop_front()); void'(q_p.pop_front()); end
      if (e_rd) begin
        if (e_done) begin
          if (!m_drain) begin
            q_i.push_back(d);
            q_p.push_back(m_fpc + AW'(2));
            m_fpc = m_fpc + AW'(2);
          end
          m_out = 0; m_drain = 0;
        end else begin
          if (!m_out) m_req = m_fpc;
          m_out = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int nreq, found, sawv;
    lat = 0;
    model_reset();
    #1;
    do_reset();

    // Zero-wait streaming from reset.
    for (int k = 0; k < 4; k++) begin
      step(0, '0, 0, 1, 0);
      chk("stream_addr", 32'(s_addr), 32'(2 * k));
      chk("stream_rd", 32'(s_rd), 1);
      if (k >= 1) chk("stream_pc_inc", 32'(s_pcinc), 32'(2 * k));
    end

    // Fill with decode stalled, then drain.
    do_reset();
    nreq = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, '0, 0, 0, 0);
      nreq += int'(s_rd);
    end
    chk("fill_reqs", 32'(nreq), 4);
    chk("fill_idle", 32'(s_rd), 0);
    for (int k = 0; k < 4; k++) begin
      step(0, '0, 0, 1, 0);
      chk("drain_pc_inc", 32'(s_pcinc), 32'(2 * k + 2));
      if (k == 0) chk("resume_addr", 32'(s_addr), 8);
    end

    // Redirect during a slow request: stale data dropped.
    do_reset();
    lat = 3;
    step(0, '0, 0, 1, 0);
    step(1, 16'h0040, 0, 1, 0);
    chk("redir_nop", 32'(s_nop), 1);
    found = 0; sawv = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, '0, 0, 1, 0);
      sawv |= int'(s_vld);
      if (s_rd && s_addr != 0 && found == 0) begin
        found = 1;
        chk("redir_addr", 32'(s_addr), 32'h40);
      end
    end
    chk("redir_found", 32'(found), 1);
    chk("stale_dropped", 32'(sawv), 0);

    // PC wrap.
    do_reset();
    lat = 0;
    step(1, 16'hFFFE, 0, 1, 0);
    chk("wrap_no_rd", 32'(s_rd), 0);
    step(0, '0, 0, 1, 0);
    chk("wrap_addr0", 32'(s_addr), 32'hFFFE);
    step(0, '0, 0, 1, 0);
    chk("wrap_addr1", 32'(s_addr), 0);
    chk("wrap_pc_inc0", 32'(s_pcinc), 0);
    step(0, '0, 0, 1, 0);
    chk("wrap_pc_inc1", 32'(s_pcinc), 2);

    // Misaligned target and memory error are sticky.
    do_reset();
    step(1, 16'h0013, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    chk("misalign_rd", 32'(s_rd), 0);
    step(0, '0, 0, 1, 0);
    chk("misalign_err", 32'(s_err), 1);
    chk("misalign_rd2", 32'(s_rd), 0);
    do_reset();
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, '0, 0, 1, 0);
      chk("memerr_sticky", 32'(s_err), 1);
      chk("memerr_blocks", 32'(s_rd), 0);
    end

    // Reset in the middle of an outstanding request.
    do_reset();
    lat = 10;
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    chk("wait_held", 32'(s_rd), 1);
    do_reset();
    lat = 0;
    step(0, '0, 0, 1, 0);
    chk("post_rst_rd", 32'(s_rd), 1);
    chk("post_rst_addr", 32'(s_addr), 0);

    // Random traffic.
    for (int c = 0; c < 2400; c++) begin
      logic r, h, e, me;
      logic [AW-1:0] rpc;
      if (c % 400 == 0) do_reset();
      if (!m_out && $urandom_range(0, 7) == 0) lat = $urandom_range(0, 3);
      r = ($urandom_range(0, 9) == 0);
      rpc = AW'($urandom) & 16'hFFFE;
      if ($urandom_range(0, 49) == 0) rpc[0] = 1'b1;
      h = ($urandom_range(0, 4) == 0);
      e = $urandom_range(0, 1) == 1;
      me = ($urandom_range(0, 499) == 0);
      step(r, rpc, h, e, me);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
